// File: rtl/delay_measure_pkg.sv
// Shared types for the trigger-to-assert delay / pulse-width measurement block.
package delay_measure_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TRIG,
    MEAS_DELAY,
    MEAS_WIDTH,
    DONE
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ABORT = 2'b01;
  localparam logic [1:0] ST_OVF   = 2'b10;

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchroniser followed by a registered level plus one-cycle rise/fall pulses.
// Level and edge pulses change on the same clock, three cycles after the input.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= RESET_VAL;
      s2    <= RESET_VAL;
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
      fall  <= ~s2 & level;
    end
  end

endmodule

// File: rtl/delay_measure.sv
// Measures trigger-rise to output-assert delay and asserted width in clk cycles;
// results are held on a valid/ready interface until accepted.
module delay_measure
  import delay_measure_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 trigger_in,
  input  logic                 delay_in_n,
  input  logic                 meas_ready,
  output logic                 meas_valid,
  output logic [CNT_WIDTH-1:0] meas_delay,
  output logic [CNT_WIDTH-1:0] meas_width,
  output logic [1:0]           meas_status,
  output logic                 missed
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic trig_lvl_unused;
  logic trig_rise;
  logic trig_fall;
  logic del_lvl;
  logic del_rise;
  logic del_fall;

  sync_edge #(.RESET_VAL(1'b0)) u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (trigger_in),
    .level (trig_lvl_unused),
    .rise  (trig_rise),
    .fall  (trig_fall)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_del_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (delay_in_n),
    .level (del_lvl),
    .rise  (del_rise),
    .fall  (del_fall)
  );

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] elapsed;
  logic [CNT_WIDTH-1:0] delay_nxt, width_nxt;
  logic [1:0]           status_nxt;
  logic                 valid_nxt, missed_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      meas_valid  <= 1'b0;
      meas_delay  <= '0;
      meas_width  <= '0;
      meas_status <= ST_OK;
      missed      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      meas_valid  <= valid_nxt;
      meas_delay  <= delay_nxt;
      meas_width  <= width_nxt;
      meas_status <= status_nxt;
      missed      <= missed_nxt;
    end
  end

  // cnt is zero in the cycle after the start event, so elapsed = cnt + 1.
  // Saturation triggers once cnt == MAX, i.e. when elapsed would no longer fit.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    delay_nxt  = meas_delay;
    width_nxt  = meas_width;
    status_nxt = meas_status;
    valid_nxt  = meas_valid;
    missed_nxt = missed;
    elapsed    = cnt + CNT_ONE;

    unique case (state)
      IDLE: begin
        if (enable) state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (trig_rise) begin
          cnt_nxt = '0;
          if (!del_lvl) begin
            delay_nxt = '0;
            state_nxt = MEAS_WIDTH;
          end else begin
            state_nxt = MEAS_DELAY;
          end
        end
      end
      MEAS_DELAY: begin
        if (cnt == CNT_MAX) begin
          delay_nxt  = CNT_MAX;
          width_nxt  = '0;
          status_nxt = ST_OVF;
          valid_nxt  = 1'b1;
          state_nxt  = DONE;
        end else if (del_fall) begin
          delay_nxt = elapsed;
          cnt_nxt   = '0;
          state_nxt = MEAS_WIDTH;
        end else if (trig_fall) begin
          delay_nxt  = elapsed;
          width_nxt  = '0;
          status_nxt = ST_ABORT;
          valid_nxt  = 1'b1;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = elapsed;
        end
      end
      MEAS_WIDTH: begin
        if (cnt == CNT_MAX) begin
          width_nxt  = CNT_MAX;
          status_nxt = ST_OVF;
          valid_nxt  = 1'b1;
          state_nxt  = DONE;
        end else if (del_rise) begin
          width_nxt  = elapsed;
          status_nxt = ST_OK;
          valid_nxt  = 1'b1;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = elapsed;
        end
      end
      DONE: begin
        if (trig_rise) missed_nxt = 1'b1;
        if (meas_ready) begin
          valid_nxt  = 1'b0;
          missed_nxt = trig_rise;
          delay_nxt  = '0;
          width_nxt  = '0;
          status_nxt = ST_OK;
          state_nxt  = enable ? WAIT_TRIG : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Disarming abandons an in-flight measurement; a pending result survives.
    if (!enable && state != DONE) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      valid_nxt  = 1'b0;
      delay_nxt  = '0;
      width_nxt  = '0;
      status_nxt = ST_OK;
    end
  end

endmodule

// File: tb/tb_delay_measure.sv
// Directed bench for delay_measure: timer model, direct, abort, overflow, missed, reset, disable.
module tb_delay_measure;

  localparam int TMR_BITS = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        trigger_in;
  logic        delay_in_n;
  logic        del_drv;
  logic        use_tmr;
  logic        meas_ready;
  logic        meas_valid;
  logic [15:0] meas_delay;
  logic [15:0] meas_width;
  logic [1:0]  meas_status;
  logic        missed;

  logic        en4, trig4, del4, ready4;
  logic        v4, m4;
  logic [3:0]  d4, w4;
  logic [1:0]  s4;

  logic        tmr_trig_q = 1'b0;
  logic        tmr_out_n  = 1'b1;
  int          tmr_rem    = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign delay_in_n = use_tmr ? tmr_out_n : del_drv;

  // Behavioural one-shot timer: asserts one cycle after seeing the trigger rise, for TMR_BITS cycles.
  always @(posedge clk) begin
    tmr_trig_q <= trigger_in;
    if (trigger_in && !tmr_trig_q) begin
      tmr_out_n <= 1'b0;
      tmr_rem   <= TMR_BITS - 1;
    end else if (!tmr_out_n) begin
      if (tmr_rem == 0) tmr_out_n <= 1'b1;
      else tmr_rem <= tmr_rem - 1;
    end
  end

  delay_measure #(.CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .trigger_in  (trigger_in),
    .delay_in_n  (delay_in_n),
    .meas_ready  (meas_ready),
    .meas_valid  (meas_valid),
    .meas_delay  (meas_delay),
    .meas_width  (meas_width),
    .meas_status (meas_status),
    .missed      (missed)
  );

  delay_measure #(.CNT_WIDTH(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (en4),
    .trigger_in  (trig4),
    .delay_in_n  (del4),
    .meas_ready  (ready4),
    .meas_valid  (v4),
    .meas_delay  (d4),
    .meas_width  (w4),
    .meas_status (s4),
    .missed      (m4)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!meas_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!meas_valid) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout meas_valid got %b want 1", name, meas_valid);
    end
  endtask

  task automatic accept();
    meas_ready = 1'b1;
    @(posedge clk);
    #1 meas_ready = 1'b0;
    @(negedge clk);
  endtask

  // Trigger rises now, output asserts d cycles later and releases w cycles after that.
  task automatic run_meas(input int d, input int w);
    trigger_in = 1'b1;
    tick(d);
    del_drv = 1'b0;
    tick(w);
    del_drv = 1'b1;
    tick(2);
    trigger_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; trigger_in = 1'b0; del_drv = 1'b1; use_tmr = 1'b0;
    meas_ready = 1'b0; en4 = 1'b0; trig4 = 1'b0; del4 = 1'b1; ready4 = 1'b0;
    tick(3);
    @(negedge clk);
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", meas_valid); end
    n_cmp++; if (meas_delay !== 16'd0) begin n_err++; $display("FAIL reset_delay got %0d want 0", meas_delay); end
    n_cmp++; if (meas_width !== 16'd0) begin n_err++; $display("FAIL reset_width got %0d want 0", meas_width); end
    n_cmp++; if (meas_status !== 2'b00) begin n_err++; $display("FAIL reset_status got %b want 00", meas_status); end
    n_cmp++; if (missed !== 1'b0) begin n_err++; $display("FAIL reset_missed got %b want 0", missed); end
    n_cmp++; if (v4 !== 1'b0) begin n_err++; $display("FAIL reset_valid4 got %b want 0", v4); end
    tick(1);
    rst_n = 1'b1; enable = 1'b1; en4 = 1'b1;
    tick(4);
  endtask

  task automatic test_timer();
    use_tmr = 1'b1;
    trigger_in = 1'b1;
    tick(3);
    trigger_in = 1'b0;
    wait_valid("timer");
    n_cmp++; if (meas_delay !== 16'd1) begin n_err++; $display("FAIL timer_delay got %0d want 1", meas_delay); end
    n_cmp++; if (meas_width !== 16'(TMR_BITS)) begin n_err++; $display("FAIL timer_width got %0d want %0d", meas_width, TMR_BITS); end
    n_cmp++; if (meas_status !== 2'b00) begin n_err++; $display("FAIL timer_status got %b want 00", meas_status); end
    accept();
    use_tmr = 1'b0;
    tick(3);
  endtask

  task automatic test_direct();
    run_meas(20, 30);
    wait_valid("direct");
    n_cmp++; if (meas_delay !== 16'd20) begin n_err++; $display("FAIL direct_delay got %0d want 20", meas_delay); end
    n_cmp++; if (meas_width !== 16'd30) begin n_err++; $display("FAIL direct_width got %0d want 30", meas_width); end
    n_cmp++; if (meas_status !== 2'b00) begin n_err++; $display("FAIL direct_status got %b want 00", meas_status); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (meas_valid !== 1'b1 || meas_delay !== 16'd20 || meas_width !== 16'd30) begin
        n_err++;
        $display("FAIL direct_hold cycle %0d got v=%b d=%0d w=%0d want v=1 d=20 w=30", i, meas_valid, meas_delay, meas_width);
      end
    end
    accept();
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL direct_drop got %b want 0", meas_valid); end
    tick(3);
  endtask

  task automatic test_abort();
    trigger_in = 1'b1;
    tick(7);
    trigger_in = 1'b0;
    wait_valid("abort");
    n_cmp++; if (meas_status !== 2'b01) begin n_err++; $display("FAIL abort_status got %b want 01", meas_status); end
    n_cmp++; if (meas_delay !== 16'd7) begin n_err++; $display("FAIL abort_delay got %0d want 7", meas_delay); end
    n_cmp++; if (meas_width !== 16'd0) begin n_err++; $display("FAIL abort_width got %0d want 0", meas_width); end
    accept();
    tick(3);
  endtask

  task automatic test_overflow();
    int k;
    trig4 = 1'b1;
    tick(20);
    trig4 = 1'b0;
    k = 0;
    @(negedge clk);
    while (!v4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (v4 !== 1'b1) begin n_err++; $display("FAIL ovf_valid got %b want 1", v4); end
    n_cmp++; if (s4 !== 2'b10) begin n_err++; $display("FAIL ovf_status got %b want 10", s4); end
    n_cmp++; if (d4 !== 4'd15) begin n_err++; $display("FAIL ovf_delay got %0d want 15", d4); end
    n_cmp++; if (w4 !== 4'd0) begin n_err++; $display("FAIL ovf_width got %0d want 0", w4); end
    ready4 = 1'b1;
    tick(1);
    ready4 = 1'b0;
    tick(2);
  endtask

  task automatic test_missed();
    run_meas(2, 3);
    wait_valid("missed_first");
    tick(2);
    trigger_in = 1'b1;
    tick(3);
    trigger_in = 1'b0;
    tick(5);
    @(negedge clk);
    n_cmp++; if (missed !== 1'b1) begin n_err++; $display("FAIL missed_set got %b want 1", missed); end
    n_cmp++; if (meas_valid !== 1'b1 || meas_delay !== 16'd2 || meas_width !== 16'd3) begin
      n_err++; $display("FAIL missed_pending got v=%b d=%0d w=%0d want v=1 d=2 w=3", meas_valid, meas_delay, meas_width);
    end
    accept();
    n_cmp++; if (missed !== 1'b0) begin n_err++; $display("FAIL missed_clear got %b want 0", missed); end
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL missed_drop got %b want 0", meas_valid); end
    tick(3);
    run_meas(4, 6);
    wait_valid("missed_next");
    n_cmp++; if (meas_delay !== 16'd4 || meas_width !== 16'd6 || meas_status !== 2'b00) begin
      n_err++; $display("FAIL missed_next got d=%0d w=%0d s=%b want d=4 w=6 s=00", meas_delay, meas_width, meas_status);
    end
    accept();
    tick(3);
  endtask

  task automatic test_reset_mid();
    bit seen;
    trigger_in = 1'b1;
    tick(3);
    del_drv = 1'b0;
    tick(10);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (meas_valid !== 1'b0 || meas_delay !== 16'd0 || meas_width !== 16'd0 || meas_status !== 2'b00 || missed !== 1'b0) begin
      n_err++; $display("FAIL rstmid_outputs got v=%b d=%0d w=%0d s=%b m=%b want all 0", meas_valid, meas_delay, meas_width, meas_status, missed);
    end
    trigger_in = 1'b0;
    del_drv = 1'b1;
    tick(3);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (meas_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_result got %b want 0", seen); end
    run_meas(5, 8);
    wait_valid("rstmid_next");
    n_cmp++; if (meas_delay !== 16'd5 || meas_width !== 16'd8 || meas_status !== 2'b00) begin
      n_err++; $display("FAIL rstmid_next got d=%0d w=%0d s=%b want d=5 w=8 s=00", meas_delay, meas_width, meas_status);
    end
    accept();
    tick(3);
  endtask

  task automatic test_enable_drop();
    bit seen;
    trigger_in = 1'b1;
    tick(8);
    enable = 1'b0;
    tick(2);
    del_drv = 1'b0;
    tick(3);
    del_drv = 1'b1;
    trigger_in = 1'b0;
    tick(4);
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (meas_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL endrop_no_result got %b want 0", seen); end
    n_cmp++; if (meas_delay !== 16'd0 || meas_width !== 16'd0 || meas_status !== 2'b00 || missed !== 1'b0) begin
      n_err++; $display("FAIL endrop_outputs got d=%0d w=%0d s=%b m=%b want all 0", meas_delay, meas_width, meas_status, missed);
    end
    run_meas(3, 4);
    wait_valid("endrop_next");
    n_cmp++; if (meas_delay !== 16'd3 || meas_width !== 16'd4 || meas_status !== 2'b00) begin
      n_err++; $display("FAIL endrop_next got d=%0d w=%0d s=%b want d=3 w=4 s=00", meas_delay, meas_width, meas_status);
    end
    accept();
    tick(2);
  endtask

  initial begin
    test_reset();
    test_timer();
    test_direct();
    test_abort();
    test_overflow();
    test_missed();
    test_reset_mid();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
